// File: rtl/div_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_seq_pkg
// Shared defines for the EX-stage ALU and the sequential divider: AluOp
// codes, divider FSM state encodings, default operand width and the
// index of each half of the {hi, lo} divide result.
// No ports.
// ---------------------------------------------------------------------------
package div_seq_pkg;

    typedef enum logic [5:0] {
        ALU_NOP   = 6'b000000,
        ALU_MFHI  = 6'b010000,
        ALU_MTHI  = 6'b010001,
        ALU_MFLO  = 6'b010010,
        ALU_MTLO  = 6'b010011,
        ALU_MULT  = 6'b011000,
        ALU_MULTU = 6'b011001,
        ALU_DIV   = 6'b011010,
        ALU_DIVU  = 6'b011011
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_FREE   = 2'b00,
        ST_BYZERO = 2'b01,
        ST_ON     = 2'b10,
        ST_END    = 2'b11
    } div_state_e;

    localparam int DIV_WIDTH_DEF = 32;

    // result_o viewed as [1:0][WIDTH-1:0]: remainder feeds hi, quotient feeds lo
    localparam int RES_LO_IDX = 0;
    localparam int RES_HI_IDX = 1;

endpackage

// File: rtl/div_seq_if.sv
// ---------------------------------------------------------------------------
// div_seq_if
// Request/result bundle between the EX stage (master) and the divider
// (slave).
//   start_i      request, held until the result is consumed
//   annul_i      flush the current operation
//   signed_div_i 1 = two's-complement divide
//   opdata1_i    dividend
//   opdata2_i    divisor
//   result_o     {remainder, quotient}
//   ready_o      result_o valid
//   busy_o       stall request to EX
// ---------------------------------------------------------------------------
interface div_seq_if
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
);

    logic               start_i;
    logic               annul_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o
    );

endinterface

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring shift-subtract step. The partial remainder is
// shifted left with the next dividend bit appended (WIDTH+1 bits) and the
// divisor is subtracted when it fits.
//   i_rem   partial remainder (always < divisor)
//   i_bit   next dividend bit, MSB first
//   i_dvs   divisor magnitude
//   o_rem   next partial remainder
//   o_qbit  quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign o_qbit  = (w_shift >= {1'b0, i_dvs});
    // When the divisor fits, the difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    assign w_diff  = w_shift[WIDTH-1:0] - i_dvs;
    assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
// Multi-cycle signed/unsigned restoring divider for the EX stage.
// Operands are converted to magnitudes on acceptance, WIDTH steps are run
// through div_step, then signs are restored (quotient truncated toward
// zero, remainder takes the dividend's sign).
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   div_seq_if slave: request in, {rem, quo}/ready/busy out
//
// state  | meaning
// FREE   | idle, waiting for a request
// BYZERO | divisor was zero, result forced to 0
// ON     | shift-subtract steps running, r_cnt counts completed steps
// END    | result valid, held until start_i drops
// ---------------------------------------------------------------------------
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_seq_if.slave    bus
);

    div_state_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_rem;
    logic [WIDTH-1:0]       r_quo;
    logic [WIDTH-1:0]       r_dvs;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic [1:0][WIDTH-1:0]  r_res;
    logic                   r_ready;

    logic                   w_req;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [WIDTH-1:0]       w_rem_nxt;
    logic                   w_qbit;
    logic [WIDTH-1:0]       w_quo_fix;
    logic [WIDTH-1:0]       w_rem_fix;

    assign w_req   = bus.start_i & ~bus.annul_i;

    assign w_a_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign w_b_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct
    // unsigned magnitude.
    assign w_a_mag = w_a_neg ? (~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
    assign w_b_mag = w_b_neg ? (~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;

    assign w_quo_fix = r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
    assign w_rem_fix = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem  (r_rem),
        .i_bit  (r_quo[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_FREE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_res   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_FREE: begin
                    r_res   <= '0;
                    r_ready <= 1'b0;
                    if (w_req) begin
                        if (bus.opdata2_i == '0) begin
                            r_state <= ST_BYZERO;
                        end else begin
                            r_state <= ST_ON;
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            r_quo   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                ST_BYZERO: begin
                    if (bus.annul_i) begin
                        r_state <= ST_FREE;
                        r_res   <= '0;
                        r_ready <= 1'b0;
                    end else begin
                        r_state <= ST_END;
                        r_res   <= '0;
                        r_ready <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (bus.annul_i) begin
                        r_state <= ST_FREE;
                        r_res   <= '0;
                        r_ready <= 1'b0;
                    end else if (r_cnt != CNT_W'(WIDTH)) begin
                        // r_quo doubles as the dividend shift register:
                        // dividend bits leave at the top, quotient bits
                        // enter at the bottom.
                        r_rem <= w_rem_nxt;
                        r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_state            <= ST_END;
                        r_res[RES_HI_IDX]  <= w_rem_fix;
                        r_res[RES_LO_IDX]  <= w_quo_fix;
                        r_ready            <= 1'b1;
                    end
                end
                ST_END: begin
                    if (bus.annul_i || !bus.start_i) begin
                        r_state <= ST_FREE;
                        r_res   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_FREE;
                    r_res   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result_o = r_res;
    assign bus.ready_o  = r_ready;
    // Stall is raised combinationally in FREE so EX holds in the same cycle
    // the request is accepted.
    assign bus.busy_o   = (r_state == ST_BYZERO) || (r_state == ST_ON) ||
                          ((r_state == ST_FREE) && w_req);

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
// Directed bench for div_seq at WIDTH=32: a table of operand/result vectors
// plus hand-written annul and reset sequences.
// ---------------------------------------------------------------------------
module tb_div_seq;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic         sg;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue a request and wait for ready_o. lat = edges after acceptance
    // until ready_o is seen (-1 on timeout); bcnt = cycles with busy_o high.
    task automatic launch(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt);
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        @(posedge clk);
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) begin
                // operands must be ignored once accepted
                bus.opdata1_i    = ~a;
                bus.opdata2_i    = b ^ 32'h0000_0005;
                bus.signed_div_i = ~sg;
            end
            if (bus.ready_o) begin
                lat = k;
                break;
            end
            if (bus.busy_o) bcnt++;
            @(posedge clk);
        end
    endtask

    task automatic run_vec(input string nm, input logic sg, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int lat;
        int bcnt;
        int exp_lat;
        exp_lat = (b == '0) ? 1 : W + 1;
        launch(sg, a, b, lat, bcnt);
        chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
        chk({nm, " result"},  128'(bus.result_o), 128'(exp));
        chk({nm, " busy cycles"}, 128'(bcnt), 128'(exp_lat));
        chk({nm, " busy in END"}, 128'(bus.busy_o), 128'(0));
        repeat (3) @(negedge clk);
        chk({nm, " hold"}, {63'd0, bus.ready_o, bus.result_o}, {63'd0, 1'b1, exp});
        bus.start_i = 1'b0;
        @(negedge clk);
        chk({nm, " release"}, {63'd0, bus.ready_o, bus.result_o}, 128'(0));
    endtask

    initial begin
        int lat;
        int bcnt;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,        {32'h0000_0002, 32'h0000_000E}};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}};
        vecs[3]  = '{1'b0, 32'd1234,       32'd0,        64'd0};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF}};
        vecs[5]  = '{1'b1, 32'h0000_0007,  32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}};
        vecs[6]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0000_0003}};
        vecs[7]  = '{1'b0, 32'hFFFF_FFF9,  32'h0000_0002, {32'h0000_0001, 32'h7FFF_FFFC}};
        vecs[8]  = '{1'b0, 32'd5,          32'd10,       {32'h0000_0005, 32'h0000_0000}};
        vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}};
        vecs[10] = '{1'b1, 32'hFFFF_FF9C,  32'h0000_0000, 64'd0};
        vecs[11] = '{1'b1, 32'h0000_0064,  32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}};

        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset outputs", {62'd0, bus.ready_o, bus.busy_o, bus.result_o}, 128'(0));
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // annul at step 10 of ON, with start still high
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        chk("annul ON", {62'd0, bus.ready_o, bus.busy_o, bus.result_o}, 128'(0));
        @(negedge clk);
        chk("annul+start in FREE", {62'd0, bus.ready_o, bus.busy_o, bus.result_o}, 128'(0));
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        run_vec("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3});

        // annul in BYZERO
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.opdata1_i = 32'd77;
        bus.opdata2_i = 32'd0;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        chk("annul BYZERO", {63'd0, bus.ready_o, bus.result_o}, 128'(0));
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);

        // annul in END
        launch(1'b0, 32'd20, 32'd4, lat, bcnt);
        chk("pre-annul END result", {63'd0, bus.ready_o, bus.result_o}, {63'd0, 1'b1, 32'h0, 32'h5});
        bus.annul_i = 1'b1;
        @(negedge clk);
        chk("annul END", {63'd0, bus.ready_o, bus.result_o}, 128'(0));
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);

        // reset mid-operation
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("reset mid-op", {62'd0, bus.ready_o, bus.busy_o, bus.result_o}, 128'(0));
        @(negedge clk);
        run_vec("after reset", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
